func_rpt_ctrl: RTL



---
 rtl/func_rpt_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/func_rpt_ctrl.sv
// ---------------------------------------------------------------------------
// func_rpt_ctrl
//
// Repeat sequencer for the function unit's shifter path. Runs one
// single-operand shift/rotate (RRC, SWPB, RRA, SXT) count+1 times. Each
// iteration feeds the previous result and carry back into the function unit.
// SWPB and SXT always run exactly once.
//
// Handshake: start is a level that is sampled only while the controller is
// idle. The request is accepted on the clock edge where start=1 and the
// state is IDLE. A start seen while busy is high, including in the done
// cycle, is dropped and is not queued. done pulses for one cycle. result
// and CVNZ_out then hold until the next run finishes or until reset.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              launch request (IDLE only)
//   op[1:0]            00 RRC, 01 SWPB, 10 RRA, 11 SXT
//   count[CNT_W-1:0]   repeat count, iterations = count+1
//   BW_in              byte mode (1 = byte)
//   operand[SIZE-1:0]  initial destination value
//   Cin_in             initial carry
//   F_in, CVNZ_in      function unit result and flags (bit 3 = C)
//   FUNC_en, FS, Cin, BW, A, B   function unit drive
//   busy, done         status (busy covers RUN and DONE)
//   result, CVNZ_out   final value and flags, held
//   o_dbg_state        current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module func_rpt_ctrl #(
    parameter int SIZE  = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             BW_in,
    input  logic [SIZE-1:0]  operand,
    input  logic             Cin_in,
    input  logic [SIZE-1:0]  F_in,
    input  logic [3:0]       CVNZ_in,
    output logic             FUNC_en,
    output logic [5:0]       FS,
    output logic             Cin,
    output logic             BW,
    output logic [SIZE-1:0]  A,
    output logic [SIZE-1:0]  B,
    output logic             busy,
    output logic             done,
    output logic [SIZE-1:0]  result,
    output logic [3:0]       CVNZ_out,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [SIZE-1:0]   r_work;
    logic              r_carry;
    logic              r_bw;
    logic [5:0]        r_fs;
    logic [CNT_W-1:0]  r_remaining;
    logic [SIZE-1:0]   r_result;
    logic [3:0]        r_cvnz;
    logic              w_last;

    // The final iteration is the one that starts with nothing left to do.
    // Testing for zero before decrementing means the counter never wraps,
    // even when count is all ones.
    assign w_last = (r_remaining == '0);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_carry     <= 1'b0;
            r_bw        <= 1'b0;
            r_fs        <= 6'b100000;
            r_remaining <= '0;
            r_result    <= '0;
            r_cvnz      <= 4'h0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work  <= operand;
                        r_carry <= Cin_in;
                        r_bw    <= BW_in;
                        // FS bits: shifter group, carry from Cin port,
                        // destination on B. The low two bits carry the op.
                        r_fs    <= {4'b1010, op};
                        // SWPB/SXT (op[0]=1) are not repeatable.
                        r_remaining <= op[0] ? '0 : count;
                    end
                end
                ST_RUN: begin
                    r_work  <= F_in;
                    r_carry <= CVNZ_in[3];
                    if (w_last) begin
                        r_result <= F_in;
                        r_cvnz   <= CVNZ_in;
                    end else begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs. The function unit inputs are driven only while iterating,
    // so the unit sees quiet inputs when it is not enabled.
    always_comb begin
        FUNC_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        B       = '0;
        Cin     = 1'b0;
        BW      = 1'b0;
        case (r_state)
            ST_RUN: begin
                FUNC_en = 1'b1;
                busy    = 1'b1;
                B       = r_work;
                Cin     = r_carry;
                BW      = r_bw;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign FS          = r_fs;
    assign A           = '0;
    assign result      = r_result;
    assign CVNZ_out    = r_cvnz;
    assign o_dbg_state = r_state;

endmodule
